// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access legality check applied when a request is accepted.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LD_WAIT   = 3'd1,
      ST_RMW_READ  = 3'd2,
      ST_RMW_WRITE = 3'd3,
      ST_RESP      = 3'd4
   } lsu_state_t;

   // Stores only accept B/H/W; the unsigned variants exist for loads alone.
   function automatic logic access_error(
      input logic        we,
      input logic [2:0]  funct3,
      input logic [31:0] addr,
      input logic [31:0] limit
   );
      logic bad_funct3;
      logic misaligned;
      bad_funct3 = 1'b1;
      case (funct3)
         F3_B, F3_H, F3_W: bad_funct3 = 1'b0;
         F3_BU, F3_HU:     bad_funct3 = we;
         default:          bad_funct3 = 1'b1;
      endcase
      misaligned = 1'b0;
      if ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
         misaligned = 1'b1;
      if (funct3 == F3_W && addr[1:0] != 2'b00)
         misaligned = 1'b1;
      return bad_funct3 | misaligned | (addr >= limit);
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane logic for the load/store unit: extracts and extends sub-word load data
// and merges sub-word store data into a previously read memory word.
module load_store_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data = {24'd0, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data = {16'd0, half_sel};
         default: load_data = word;
      endcase
   end

   // Only the addressed lane changes; the rest of the word is written back as read.
   always_comb begin
      merged_word = word;
      case (funct3)
         F3_B: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         F3_H: begin
            if (addr_lo[1])
               merged_word[31:16] = wdata;
            else
               merged_word[15:0] = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed data memory: one request at a
// time, sub-word loads with extension, sub-word stores via read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT  = 32'd512,
   parameter logic [31:0] RESET_RDATA = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable
);

   lsu_state_t  state;
   logic [1:0]  addr_lo_q;
   logic [2:0]  funct3_q;
   logic [15:0] wdata_q;
   logic        access_err;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign access_err       = access_error(req_we, req_funct3, req_addr, ADDR_LIMIT);
   assign req_ready        = (state == ST_IDLE);
   assign resp_valid       = (state == ST_RESP);
   assign mem_write_enable = (state == ST_RMW_WRITE);

   // The read must be presented in the accept cycle so data returns the cycle after.
   assign mem_read_addr = (state == ST_IDLE && req_valid) ? {req_addr[31:2], 2'b00} : 32'd0;

   load_store_align u_align (
      .word        (mem_read_data),
      .addr_lo     (addr_lo_q),
      .funct3      (funct3_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Word stores skip the read and go straight to the write state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ST_IDLE;
         resp_rdata     <= RESET_RDATA;
         resp_err       <= 1'b0;
         mem_write_addr <= 32'd0;
         mem_write_data <= 32'd0;
         addr_lo_q      <= 2'b00;
         funct3_q       <= 3'b000;
         wdata_q        <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_lo_q <= req_addr[1:0];
                  funct3_q  <= req_funct3;
                  wdata_q   <= req_wdata[15:0];
                  if (access_err) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= ST_RESP;
                  end else if (!req_we) begin
                     state <= ST_LD_WAIT;
                  end else begin
                     mem_write_addr <= {req_addr[31:2], 2'b00};
                     if (req_funct3 == F3_W) begin
                        mem_write_data <= req_wdata;
                        state          <= ST_RMW_WRITE;
                     end else begin
                        state <= ST_RMW_READ;
                     end
                  end
               end
            end
            ST_LD_WAIT: begin
               resp_rdata <= load_data;
               resp_err   <= 1'b0;
               state      <= ST_RESP;
            end
            ST_RMW_READ: begin
               mem_write_data <= merged_word;
               state          <= ST_RMW_WRITE;
            end
            ST_RMW_WRITE: begin
               resp_rdata <= 32'd0;
               resp_err   <= 1'b0;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               resp_err <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory;
// expected values are hand-computed constants.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_read_data = 32'd0;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;

   logic [31:0] mem [0:127];
   int          check_count = 0;
   int          error_count = 0;

   load_store_unit #(.ADDR_LIMIT(32'd512), .RESET_RDATA(32'd0)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .mem_read_addr    (mem_read_addr),
      .mem_read_data    (mem_read_data),
      .mem_write_addr   (mem_write_addr),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable)
   );

   always #5 clk = ~clk;

   // Synchronous memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      mem_read_data <= mem[mem_read_addr[8:2]];
      if (mem_write_enable)
         mem[mem_write_addr[8:2]] <= mem_write_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic driveReq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // Issues one request and watches the unit until its response, counting cycles from accept.
   task automatic applyStimulus(
      input  logic        we,
      input  logic [2:0]  f3,
      input  logic [31:0] addr,
      input  logic [31:0] wdata,
      output int          lat,
      output logic [31:0] rdata,
      output logic        err,
      output int          wr_count,
      output int          wr_cycle,
      output logic [31:0] wr_addr,
      output logic [31:0] wr_data,
      output int          busy_ready
   );
      lat = -1; rdata = 32'hFFFF_FFFF; err = 1'b0;
      wr_count = 0; wr_cycle = -1; wr_addr = 32'd0; wr_data = 32'd0; busy_ready = 0;
      @(negedge clk);
      driveReq(we, f3, addr, wdata);
      req_valid = 1'b1;
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (mem_write_enable) begin
            wr_count++;
            wr_cycle = k;
            wr_addr  = mem_write_addr;
            wr_data  = mem_write_data;
         end
         if (resp_valid) begin
            lat   = k;
            rdata = resp_rdata;
            err   = resp_err;
            break;
         end
         if (req_ready) busy_ready++;
         @(negedge clk);
      end
   endtask

   task automatic runOp(
      input string       tag,
      input logic        we,
      input logic [2:0]  f3,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input int          exp_lat,
      input logic [31:0] exp_rdata,
      input logic        exp_err,
      input int          exp_wr_cycle,
      input logic [31:0] exp_wr_data
   );
      int lat, wr_count, wr_cycle, busy_ready;
      logic [31:0] rdata, wr_addr, wr_data;
      logic err;
      applyStimulus(we, f3, addr, wdata, lat, rdata, err, wr_count, wr_cycle, wr_addr, wr_data, busy_ready);
      checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, ".rdata"}, rdata, exp_rdata);
      checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      checkOutput({tag, ".ready_busy"}, 32'(busy_ready), 32'd0);
      checkOutput({tag, ".wr_count"}, 32'(wr_count), (exp_wr_cycle > 0) ? 32'd1 : 32'd0);
      if (exp_wr_cycle > 0) begin
         checkOutput({tag, ".wr_cycle"}, 32'(wr_cycle), 32'(exp_wr_cycle));
         checkOutput({tag, ".wr_addr"}, wr_addr, {addr[31:2], 2'b00});
         checkOutput({tag, ".wr_data"}, wr_data, exp_wr_data);
      end
   endtask

   logic        b_we    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [2:0]  b_f3    [4] = '{F3_W, F3_W, F3_B, F3_BU};
   logic [31:0] b_addr  [4] = '{32'h40, 32'h40, 32'h41, 32'h41};
   logic [31:0] b_wdata [4] = '{32'hCAFE_F00D, 32'd0, 32'h0000_0099, 32'd0};
   logic [31:0] b_exp   [4] = '{32'd0, 32'hCAFE_F00D, 32'd0, 32'h0000_0099};

   initial begin
      int idx, resp_seen, overlap;
      logic outstanding, advance;
      logic we_seen, rv_seen;

      for (int i = 0; i < 128; i++) mem[i] = 32'd0;
      mem[8]  = 32'h80FF_7F01;
      mem[12] = 32'h1122_3344;

      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("reset.req_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("reset.rdata", resp_rdata, 32'd0);
      checkOutput("reset.err", {31'd0, resp_err}, 32'd0);
      checkOutput("reset.write_enable", {31'd0, mem_write_enable}, 32'd0);
      checkOutput("reset.read_addr", mem_read_addr, 32'd0);
      checkOutput("reset.write_addr", mem_write_addr, 32'd0);
      rst = 1'b1;

      runOp("sw_10", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("sw_10.pulse_end", {31'd0, resp_valid}, 32'd0);
      checkOutput("sw_10.ready_after", {31'd0, req_ready}, 32'd1);
      runOp("lw_10", 1'b0, F3_W, 32'h10, 32'd0, 2, 32'hDEAD_BEEF, 1'b0, 0, 32'd0);

      runOp("lb_23", 1'b0, F3_B, 32'h23, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 0, 32'd0);
      runOp("lbu_23", 1'b0, F3_BU, 32'h23, 32'd0, 2, 32'h0000_0080, 1'b0, 0, 32'd0);
      runOp("lb_21", 1'b0, F3_B, 32'h21, 32'd0, 2, 32'h0000_007F, 1'b0, 0, 32'd0);
      runOp("lh_22", 1'b0, F3_H, 32'h22, 32'd0, 2, 32'hFFFF_80FF, 1'b0, 0, 32'd0);
      runOp("lhu_20", 1'b0, F3_HU, 32'h20, 32'd0, 2, 32'h0000_7F01, 1'b0, 0, 32'd0);

      runOp("sb_31", 1'b1, F3_B, 32'h31, 32'h0000_00AB, 3, 32'd0, 1'b0, 2, 32'h1122_AB44);
      runOp("sh_32", 1'b1, F3_H, 32'h32, 32'h0000_5566, 3, 32'd0, 1'b0, 2, 32'h5566_AB44);
      runOp("lw_30", 1'b0, F3_W, 32'h30, 32'd0, 2, 32'h5566_AB44, 1'b0, 0, 32'd0);

      runOp("err_lw_06", 1'b0, F3_W, 32'h06, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0);
      runOp("lw_20", 1'b0, F3_W, 32'h20, 32'd0, 2, 32'h80FF_7F01, 1'b0, 0, 32'd0);
      runOp("err_lh_05", 1'b0, F3_H, 32'h05, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0);
      runOp("err_f3_011", 1'b0, 3'b011, 32'h08, 32'd0, 1, 32'd0, 1'b1, 0, 32'd0);
      runOp("err_sbu", 1'b1, F3_BU, 32'h08, 32'h0000_0011, 1, 32'd0, 1'b1, 0, 32'd0);
      runOp("err_sw_200", 1'b1, F3_W, 32'h200, 32'h1234_5678, 1, 32'd0, 1'b1, 0, 32'd0);
      runOp("lw_1fc", 1'b0, F3_W, 32'h1FC, 32'd0, 2, 32'd0, 1'b0, 0, 32'd0);
      checkOutput("err_sw_200.mem_word0", mem[0], 32'd0);

      // Back-to-back: req_valid held high, each op replaced right after its accept.
      idx = 0; resp_seen = 0; overlap = 0; outstanding = 1'b0; advance = 1'b0;
      @(negedge clk);
      driveReq(b_we[0], b_f3[0], b_addr[0], b_wdata[0]);
      req_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && resp_seen < 4; cyc++) begin
         if (advance) begin
            advance = 1'b0;
            idx++;
            if (idx < 4) driveReq(b_we[idx], b_f3[idx], b_addr[idx], b_wdata[idx]);
            else req_valid = 1'b0;
         end
         if (resp_valid) begin
            if (!outstanding) overlap++;
            checkOutput($sformatf("b2b.rdata%0d", resp_seen), resp_rdata, b_exp[resp_seen]);
            resp_seen++;
            outstanding = 1'b0;
         end
         if (req_ready && outstanding) overlap++;
         if (req_ready && req_valid) begin
            outstanding = 1'b1;
            advance     = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("b2b.responses", 32'(resp_seen), 32'd4);
      checkOutput("b2b.accepts", 32'(idx), 32'd4);
      checkOutput("b2b.overlap", 32'(overlap), 32'd0);
      checkOutput("b2b.mem_40", mem[16], 32'hCAFE_990D);

      // Reset in the middle of a read-modify-write: the write must never happen.
      runOp("pre_reset_lw", 1'b0, F3_W, 32'h30, 32'd0, 2, 32'h5566_AB44, 1'b0, 0, 32'd0);
      @(negedge clk);
      driveReq(1'b1, F3_B, 32'h31, 32'h0000_00CC);
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid.accepted", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b0;
      rst = 1'b0;
      we_seen = 1'b0; rv_seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         we_seen |= mem_write_enable;
         rv_seen |= resp_valid;
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid.ready_after", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_mid.rdata", resp_rdata, 32'd0);
      repeat (4) begin
         we_seen |= mem_write_enable;
         rv_seen |= resp_valid;
         @(negedge clk);
      end
      checkOutput("rst_mid.write_enable", {31'd0, we_seen}, 32'd0);
      checkOutput("rst_mid.resp_valid", {31'd0, rv_seen}, 32'd0);
      checkOutput("rst_mid.mem_30", mem[12], 32'h5566_AB44);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory and owns its read/write ports.
- Accepts one load/store request at a time from the CPU MEM stage.
- Handles byte and halfword accesses: lane extraction and sign/zero extension on loads, read-modify-write on sub-word stores.
- Checks alignment, funct3 and address range, and returns one response per request.

Parameters:
- ADDR_LIMIT, 32'd512: byte-address bound; addr >= ADDR_LIMIT is an access error.
- RESET_RDATA, 32'd0: value of rdata after reset.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: unit can accept; high only in IDLE.
- req_we, in, 1: 1 = store, 0 = load.
- req_funct3, in, 3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data; the value is taken from the low bits.
- resp_valid, out, 1: one-cycle response pulse.
- resp_rdata, out, 32: extended load data; 0 for stores and errors.
- resp_err, out, 1: misaligned, illegal funct3 or out-of-range access.
- mem_read_addr, out, 32: byte address to memory, always word-aligned (low 2 bits 0).
- mem_read_data, in, 32: memory read data, valid one cycle after the address.
- mem_write_addr, out, 32: word-aligned byte address to memory.
- mem_write_data, out, 32: full word to write.
- mem_write_enable, out, 1: write strobe, single cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst==0 at any posedge gives:
  - state IDLE; resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA, mem_write_enable=0.
  - mem_read_addr and mem_write_addr = 0.
  - An in-flight request is dropped. A pending RMW write is NOT issued.
- States: IDLE, LD_WAIT, RMW_READ, RMW_WRITE, RESP.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at a posedge (cycle N). Request fields are registered at N and must not be needed afterwards.
- Error check at accept. Any of the following is an error:
  - funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores.
  - halfword with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr >= ADDR_LIMIT.
- Error path: no memory write; RESP at N+1 with resp_err=1, rdata=0.
- Load: mem_read_addr={addr[31:2],2'b00} presented during N → LD_WAIT.
  - In LD_WAIT, capture mem_read_data. Select lane addr[1:0] for byte, addr[1] for half.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - RESP at N+2 (resp_valid=1, rdata valid, err=0).
- Store word: mem_write_enable=1 with addr/data during N+1 → RESP at N+2.
- Store byte/half (read-modify-write):
  - N: issue read → RMW_READ.
  - N+1: merge req_wdata[7:0] or [15:0] into the captured word at the selected lane and register the merged word → RMW_WRITE.
  - N+2: mem_write_enable=1 → RESP at N+3.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; next state IDLE. Back-to-back requests are therefore accepted at most every 3/3/4 cycles (load/SW/sub-word).
- mem_write_enable is asserted only in the SW write cycle or RMW_WRITE; never during error or load.
- resp_rdata holds its value until the next response; it is cleared to 0 on store and error responses.
- The memory read port may be driven in any state. Its value is don't-care outside IDLE→LD_WAIT and IDLE→RMW_READ.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum lsu_state_t.
- Sub-module load_store_align (combinational): inputs word, addr[1:0], funct3, wdata; outputs extended load data and merged store word. The unit instantiates it once and holds only the FSM and registers.

Test Plan:
- Reset: rst=0 for 2 cycles mid RMW_READ → resp_valid=0, mem_write_enable never pulses, req_ready=1 in the cycle after release, rdata=0.
- SW: addr 0x10, wdata 0xDEADBEEF at N → write_enable=1 with addr 0x10 at N+1; LW 0x10 → rdata 0xDEADBEEF, resp_valid at N+2.
- LB/LBU/LH/LHU on word 0x80FF7F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- RMW: word 0x11223344 at 0x30; SB 0x31 wdata 0xAB → write data 0x1122AB44 at N+2, resp at N+3. Then SH 0x32 wdata 0x5566 → 0x5566AB44.
- Errors: LW 0x06, LH 0x05, funct3 3'b011, SW 0x200 (ADDR_LIMIT) → resp_err=1 at N+1, rdata 0, no write_enable.
- Back-to-back: req_valid held high with 4 queued ops → req_ready low outside IDLE; exactly one resp_valid per op, in order, no overlap.
